// File: rtl/tan_cordic.sv
// Single-precision tangent of an angle in degrees: degree->radian float multiply,
// CORDIC rotation in Q2.30, serial restoring Y/X divide, then truncating float pack.
module tan_cordic #(
   parameter int ITER = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] degree_angle,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] a_wire,
   output logic [31:0] radian_angle,
   output logic        start,
   output logic        startLoop,
   output logic        Y_signal,
   output logic        X_signal,
   output logic        angle_signal,
   output logic        t1_signal,
   output logic        t2_signal,
   output logic        verify_angleGreaterA,
   output logic        angleGreaterA,
   output logic        doneLoop
);

   localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MUL    = 3'd1;
   localparam logic [2:0] S_FIX    = 3'd2;
   localparam logic [2:0] S_LOOP_T = 3'd3;
   localparam logic [2:0] S_LOOP_U = 3'd4;
   localparam logic [2:0] S_DIV    = 3'd5;
   localparam logic [2:0] S_NORM   = 3'd6;

   localparam logic [31:0] K_Q230    = 32'h26DD3B6A;
   localparam logic [31:0] QNAN      = 32'h7FC00000;
   localparam logic [31:0] ATAN0_FLT = 32'h3F490FDB;

   function automatic logic [31:0] deg_to_rad(input logic [31:0] f);
      logic [47:0]       p;
      logic [22:0]       frac;
      logic              g;
      logic              s;
      logic [23:0]       m;
      logic signed [9:0] e;
      if (f[30:23] == 8'd0) return 32'd0;
      if (f[30:23] == 8'hFF) return QNAN;
      p = 48'({1'b1, f[22:0]}) * 48'(24'h8EFA35);
      if (p[47]) begin
         frac = p[46:24];
         g    = p[23];
         s    = |p[22:0];
         e    = $signed({2'b00, f[30:23]}) - 10'sd5;
      end else begin
         frac = p[45:23];
         g    = p[22];
         s    = |p[21:0];
         e    = $signed({2'b00, f[30:23]}) - 10'sd6;
      end
      // round-to-nearest-even; a carry out of the mantissa bumps the exponent
      m = {1'b0, frac} + {23'd0, g & (s | frac[0])};
      if (m[23]) e = e + 10'sd1;
      if (e <= 10'sd0) return {f[31], 31'd0};
      return {f[31], e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] rad_to_q230(input logic [30:0] f);
      logic [31:0] m;
      m = {8'd0, 1'b1, f[22:0]};
      if (f[30:23] == 8'd0) return 32'd0;
      if (f[30:23] > 8'd127) return 32'h7FFFFFFF;
      if (f[30:23] >= 8'd120) return m << (f[30:23] - 8'd120);
      return m >> (8'd120 - f[30:23]);
   endfunction

   function automatic logic [31:0] atan_fix(input logic [IW-1:0] idx);
      case (int'(idx))
         0:  return 32'h3243F6A8;  1:  return 32'h1DAC6705;
         2:  return 32'h0FADBAFC;  3:  return 32'h07F56EA6;
         4:  return 32'h03FEAB76;  5:  return 32'h01FFD55B;
         6:  return 32'h00FFFAAA;  7:  return 32'h007FFF55;
         8:  return 32'h003FFFEA;  9:  return 32'h001FFFFD;
         10: return 32'h000FFFFF;  11: return 32'h0007FFFF;
         12: return 32'h0003FFFF;  13: return 32'h0001FFFF;
         14: return 32'h0000FFFF;  15: return 32'h00007FFF;
         16: return 32'h00003FFF;  17: return 32'h00001FFF;
         18: return 32'h00000FFF;  19: return 32'h000007FF;
         20: return 32'h000003FF;  21: return 32'h000001FF;
         22: return 32'h000000FF;  23: return 32'h0000007F;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] atan_flt(input logic [IW-1:0] idx);
      case (int'(idx))
         0:  return ATAN0_FLT;     1:  return 32'h3EED6338;
         2:  return 32'h3E7ADBB0;  3:  return 32'h3DFEADD5;
         4:  return 32'h3D7FAADE;  5:  return 32'h3CFFEAAE;
         6:  return 32'h3C7FFAAB;  7:  return 32'h3BFFFEAB;
         8:  return 32'h3B7FFFAB;  9:  return 32'h3AFFFFEB;
         10: return 32'h3A7FFFFB;  11: return 32'h39FFFFFF;
         12: return 32'h39800000;  13: return 32'h39000000;
         14: return 32'h38800000;  15: return 32'h38000000;
         16: return 32'h37800000;  17: return 32'h37000000;
         18: return 32'h36800000;  19: return 32'h36000000;
         20: return 32'h35800000;  21: return 32'h35000000;
         22: return 32'h34800000;  23: return 32'h34000000;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [4:0] lead_zeros(input logic [31:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int b = 0; b < 32; b++) if (v[b]) n = 5'(31 - b);
      return n;
   endfunction

   logic [2:0]        state_q, state_d;
   logic              first_q, first_d;
   logic              fix_ph_q, fix_ph_d;
   logic              bypass_q, bypass_d;
   logic              sign_q, sign_d;
   logic [31:0]       deg_q, deg_d;
   logic [31:0]       rad_q, rad_d;
   logic [31:0]       bypass_res_q, bypass_res_d;
   logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d, t1_q, t1_d, t2_q, t2_d;
   logic [IW-1:0]     iter_q, iter_d;
   logic [31:0]       rem_q, rem_d, num_q, num_d, quot_q, quot_d;
   logic [4:0]        div_cnt_q, div_cnt_d;
   logic              done_q, done_d;
   logic [31:0]       result_q, result_d;
   logic [31:0]       a_wire_q, a_wire_d;
   logic              start_q, start_d;
   logic              loop_q, loop_d;
   logic              agrea_q, agrea_d;
   logic              done_loop_q, done_loop_d;
   logic              xs_q, xs_d, ys_q, ys_d, zs_q, zs_d;
   logic              t1s_q, t1s_d, t2s_q, t2s_d, vs_q, vs_d;

   logic [31:0]       y_pos;
   logic [32:0]       rem_ext;
   logic [4:0]        lz;
   logic [31:0]       norm_m;

   always_comb begin
      // NOTE: every next-state value defaults to its register (strobes to 0), so no path leaves a latch.
      state_d      = state_q;      first_d  = first_q;   fix_ph_d = fix_ph_q;
      bypass_d     = bypass_q;     sign_d   = sign_q;    deg_d    = deg_q;
      rad_d        = rad_q;        bypass_res_d = bypass_res_q;
      x_d = x_q;  y_d = y_q;  z_d = z_q;  t1_d = t1_q;  t2_d = t2_q;
      iter_d       = iter_q;       rem_d    = rem_q;     num_d    = num_q;
      quot_d       = quot_q;       div_cnt_d = div_cnt_q;
      done_d       = done_q;       result_d = result_q;  a_wire_d = a_wire_q;
      loop_d       = loop_q;       agrea_d  = agrea_q;
      start_d = 1'b0;  done_loop_d = 1'b0;
      xs_d = 1'b0;  ys_d = 1'b0;  zs_d = 1'b0;  t1s_d = 1'b0;  t2s_d = 1'b0;  vs_d = 1'b0;
      y_pos   = '0;
      rem_ext = {rem_q, num_q[31]};
      lz      = lead_zeros(quot_q);
      norm_m  = quot_q << lz;

      case (state_q)
         S_IDLE: begin
            if (first_q || (degree_angle != deg_q)) begin
               deg_d   = degree_angle;
               first_d = 1'b0;
               start_d = 1'b1;
               done_d  = 1'b0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            rad_d   = deg_to_rad(deg_q);
            state_d = S_FIX;
         end
         S_FIX: begin
            if (!fix_ph_q) begin
               z_d      = $signed(rad_to_q230(rad_q[30:0]));
               sign_d   = deg_q[31];
               fix_ph_d = 1'b1;
               bypass_d = 1'b1;
               if (deg_q[30:0] >= 31'h42B40000) bypass_res_d = QNAN;
               else if (deg_q[30:23] == 8'd0) bypass_res_d = {deg_q[31], 31'd0};
               else bypass_d = 1'b0;
            end else begin
               fix_ph_d = 1'b0;
               if (bypass_q) begin
                  state_d = S_NORM;
               end else begin
                  x_d     = $signed(K_Q230);
                  y_d     = '0;
                  iter_d  = '0;
                  loop_d  = 1'b1;
                  state_d = S_LOOP_T;
               end
            end
         end
         S_LOOP_T: begin
            t1_d     = x_q >>> iter_q;
            t2_d     = y_q >>> iter_q;
            a_wire_d = atan_flt(iter_q);
            agrea_d  = ~z_q[31];
            t1s_d = 1'b1;  t2s_d = 1'b1;  vs_d = 1'b1;
            state_d  = S_LOOP_U;
         end
         S_LOOP_U: begin
            if (agrea_q) begin
               x_d = x_q - t2_q;
               y_d = y_q + t1_q;
               z_d = z_q - $signed(atan_fix(iter_q));
            end else begin
               x_d = x_q + t2_q;
               y_d = y_q - t1_q;
               z_d = z_q + $signed(atan_fix(iter_q));
            end
            xs_d = 1'b1;  ys_d = 1'b1;  zs_d = 1'b1;
            if (iter_q == IW'(ITER - 1)) begin
               // tiny negative sines at zero angle clamp to 0 for the unsigned divide
               y_pos       = y_d[31] ? 32'd0 : y_d;
               rem_d       = {8'd0, y_pos[31:8]};
               num_d       = {y_pos[7:0], 24'd0};
               quot_d      = '0;
               div_cnt_d   = '0;
               done_loop_d = 1'b1;
               loop_d      = 1'b0;
               state_d     = S_DIV;
            end else begin
               iter_d  = iter_q + IW'(1);
               state_d = S_LOOP_T;
            end
         end
         S_DIV: begin
            if (rem_ext >= {1'b0, x_q}) begin
               rem_d  = 32'(rem_ext - {1'b0, x_q});
               quot_d = {quot_q[30:0], 1'b1};
            end else begin
               rem_d  = rem_ext[31:0];
               quot_d = {quot_q[30:0], 1'b0};
            end
            num_d     = num_q << 1;
            div_cnt_d = div_cnt_q + 5'd1;
            if (div_cnt_q == 5'd31) state_d = S_NORM;
         end
         S_NORM: begin
            if (bypass_q) result_d = bypass_res_q;
            else if (quot_q == 32'd0) result_d = {sign_q, 31'd0};
            else result_d = {sign_q, 8'd134 - {3'd0, lz}, norm_m[30:8]};
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses nonblocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;  first_q <= 1'b1;  fix_ph_q <= 1'b0;  bypass_q <= 1'b0;
         sign_q   <= 1'b0;    deg_q   <= '0;    rad_q    <= '0;    bypass_res_q <= '0;
         x_q <= '0;  y_q <= '0;  z_q <= '0;  t1_q <= '0;  t2_q <= '0;  iter_q <= '0;
         rem_q    <= '0;      num_q   <= '0;    quot_q   <= '0;    div_cnt_q <= '0;
         done_q   <= 1'b0;    result_q <= '0;   a_wire_q <= ATAN0_FLT;
         start_q  <= 1'b0;    loop_q  <= 1'b0;  agrea_q  <= 1'b0;  done_loop_q <= 1'b0;
         xs_q <= 1'b0;  ys_q <= 1'b0;  zs_q <= 1'b0;  t1s_q <= 1'b0;  t2s_q <= 1'b0;  vs_q <= 1'b0;
      end else begin
         state_q  <= state_d;  first_q <= first_d;  fix_ph_q <= fix_ph_d;  bypass_q <= bypass_d;
         sign_q   <= sign_d;   deg_q   <= deg_d;    rad_q    <= rad_d;     bypass_res_q <= bypass_res_d;
         x_q <= x_d;  y_q <= y_d;  z_q <= z_d;  t1_q <= t1_d;  t2_q <= t2_d;  iter_q <= iter_d;
         rem_q    <= rem_d;    num_q   <= num_d;    quot_q   <= quot_d;    div_cnt_q <= div_cnt_d;
         done_q   <= done_d;   result_q <= result_d; a_wire_q <= a_wire_d;
         start_q  <= start_d;  loop_q  <= loop_d;   agrea_q  <= agrea_d;   done_loop_q <= done_loop_d;
         xs_q <= xs_d;  ys_q <= ys_d;  zs_q <= zs_d;  t1s_q <= t1s_d;  t2s_q <= t2s_d;  vs_q <= vs_d;
      end
   end

   assign done                 = done_q;
   assign result               = result_q;
   assign a_wire               = a_wire_q;
   assign radian_angle         = rad_q;
   assign start                = start_q;
   assign startLoop            = loop_q;
   assign Y_signal             = ys_q;
   assign X_signal             = xs_q;
   assign angle_signal         = zs_q;
   assign t1_signal            = t1s_q;
   assign t2_signal            = t2s_q;
   assign verify_angleGreaterA = vs_q;
   assign angleGreaterA        = agrea_q;
   assign doneLoop             = done_loop_q;

endmodule

// File: tb/tb_tan_cordic.sv
// Directed bench for tan_cordic: a vector table of angles with hand-computed tangents,
// plus sequences for an input change mid-operation and a reset mid-operation.
module tb_tan_cordic;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] degree_angle;
   logic        done;
   logic [31:0] result;
   logic [31:0] a_wire;
   logic [31:0] radian_angle;
   logic        start;
   logic        startLoop;
   logic        Y_signal;
   logic        X_signal;
   logic        angle_signal;
   logic        t1_signal;
   logic        t2_signal;
   logic        verify_angleGreaterA;
   logic        angleGreaterA;
   logic        doneLoop;

   tan_cordic #(.ITER(24)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .degree_angle        (degree_angle),
      .done                (done),
      .result              (result),
      .a_wire              (a_wire),
      .radian_angle        (radian_angle),
      .start               (start),
      .startLoop           (startLoop),
      .Y_signal            (Y_signal),
      .X_signal            (X_signal),
      .angle_signal        (angle_signal),
      .t1_signal           (t1_signal),
      .t2_signal           (t2_signal),
      .verify_angleGreaterA(verify_angleGreaterA),
      .angleGreaterA       (angleGreaterA),
      .doneLoop            (doneLoop)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] deg;
      logic [31:0] res;
      bit          approx;
      bit          timing;
      bit          chk_rad;
      logic [31:0] rad;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs[NV];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // float results within 32 ulps (about 2^-18 relative) of the expected pattern
   task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp);
      int diff;
      n_checks++;
      diff = int'({1'b0, act[30:0]}) - int'({1'b0, exp[30:0]});
      if (diff < 0) diff = -diff;
      if ($isunknown(act) || act[31] !== exp[31] || diff > 32) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (+-32 ulp)", name, act, exp);
      end
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!start && n < 20);
      check({name, "_start"}, 32'(start), 32'd1);
   endtask

   // Called at the negedge of cycle S (cyc0 cycles later if the caller already advanced).
   task automatic run_op(input string name, input int cyc0, input logic [31:0] exp_res,
                         input bit approx, input bit timing, input bit chk_rad,
                         input logic [31:0] exp_rad);
      int          cyc = cyc0;
      int          nv = 0;
      int          nd = 0;
      logic [31:0] rad = '0;
      logic [3:0]  lp = '0;
      logic        st1 = 1'b0;
      while (!done && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            rad = radian_angle;
            st1 = start;
         end
         if (cyc == 2)  lp[3] = startLoop;
         if (cyc == 3)  lp[2] = startLoop;
         if (cyc == 50) lp[1] = startLoop;
         if (cyc == 51) lp[0] = startLoop;
         if (verify_angleGreaterA) nv++;
         if (doneLoop) nd++;
      end
      check({name, "_done"}, 32'(done), 32'd1);
      if (approx) check_near({name, "_result"}, result, exp_res);
      else        check({name, "_result"}, result, exp_res);
      if (timing) check({name, "_latency"}, cyc, 84);
      if (cyc0 == 0) begin
         check({name, "_start_pulse"}, 32'(st1), 32'd0);
         if (chk_rad) check({name, "_radian"}, rad, exp_rad);
         if (timing) begin
            check({name, "_startloop_window"}, 32'(lp), 32'b0110);
            check({name, "_evals"}, nv, 24);
            check({name, "_doneloop"}, nd, 1);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"deg60",   32'h42700000, 32'h3FDDB3D7, 1'b1, 1'b1, 1'b1, 32'h3F860A92};
      vecs[1]  = '{"deg45",   32'h42340000, 32'h3F800000, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[2]  = '{"degm30",  32'hC1F00000, 32'hBF13CD3A, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{"zero",    32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h0};
      vecs[4]  = '{"deg90",   32'h42B40000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{"negzero", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{"deg30",   32'h41F00000, 32'h3F13CD3A, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[7]  = '{"degm60",  32'hC2700000, 32'hBFDDB3D7, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[8]  = '{"nan",     32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[9]  = '{"inf",     32'h7F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[10] = '{"degm90",  32'hC2B40000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 32'h0};

      rst          = 1'b1;
      degree_angle = vecs[0].deg;
      repeat (3) @(negedge clk);
      check("rst_done",      32'(done),      32'd0);
      check("rst_result",    result,         32'd0);
      check("rst_a_wire",    a_wire,         32'h3F490FDB);
      check("rst_radian",    radian_angle,   32'd0);
      check("rst_start",     32'(start),     32'd0);
      check("rst_startloop", 32'(startLoop), 32'd0);
      check("rst_doneloop",  32'(doneLoop),  32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (i > 0) degree_angle = vecs[i].deg;
         wait_start(vecs[i].name);
         run_op(vecs[i].name, 0, vecs[i].res, vecs[i].approx, vecs[i].timing,
                vecs[i].chk_rad, vecs[i].rad);
      end

      // input change while busy: first result completes, then the new value is captured
      degree_angle = 32'h42340000;
      wait_start("chg_a");
      repeat (20) @(negedge clk);
      degree_angle = 32'h41F00000;
      run_op("chg_a", 20, 32'h3F800000, 1'b1, 1'b1, 1'b0, 32'h0);
      wait_start("chg_b");
      run_op("chg_b", 0, 32'h3F13CD3A, 1'b1, 1'b1, 1'b0, 32'h0);

      // reset mid-operation clears outputs at once, then the same input is recaptured
      degree_angle = 32'h42700000;
      wait_start("rst_mid");
      repeat (30) @(negedge clk);
      check("rst_mid_busy", 32'(startLoop), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_startloop", 32'(startLoop), 32'd0);
      check("rst_mid_done",      32'(done),      32'd0);
      check("rst_mid_result",    result,         32'd0);
      check("rst_mid_radian",    radian_angle,   32'd0);
      check("rst_mid_a_wire",    a_wire,         32'h3F490FDB);
      @(negedge clk);
      rst = 1'b0;
      wait_start("rst_re");
      run_op("rst_re", 0, 32'h3FDDB3D7, 1'b1, 1'b1, 1'b1, 32'h3F860A92);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
